// File: rtl/impartitor_16b_pkg.sv
// ============================================================================
//  impartitor_16b_pkg
//  Shared width default and FSM state encoding for the restoring divider.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package impartitor_16b_pkg;

    localparam int WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/impartitor_16b_scazator_cla.sv
// ============================================================================
//  impartitor_16b_scazator_cla
//  Carry-lookahead subtractor: diff = x + ~y + 1, borrow = ~carry_out.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module impartitor_16b_scazator_cla #(
    parameter int N = 17
) (
    input  logic [N-1:0] x_i,
    input  logic [N-1:0] y_i,
    output logic [N-1:0] diff_o,
    output logic         borrow_o
);
    import impartitor_16b_pkg::*;

    logic [N-1:0] yn_w;
    logic [N-1:0] p_w;
    logic [N-1:0] g_w;
    logic [N:0]   c_w;

    assign yn_w   = ~y_i;
    assign p_w    = x_i ^ yn_w;
    assign g_w    = x_i & yn_w;
    assign c_w[0] = 1'b1;

    generate
        for (genvar i = 0; i < N; i++) begin : g_carry
            assign c_w[i+1] = g_w[i] | (p_w[i] & c_w[i]);
        end
    endgenerate

    assign diff_o   = p_w ^ c_w[N-1:0];
    assign borrow_o = ~c_w[N];

endmodule

`default_nettype wire

// File: rtl/impartitor_16b.sv
// ============================================================================
//  impartitor_16b
//  Sequential restoring divider, one quotient bit per clock.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module impartitor_16b
    import impartitor_16b_pkg::*;
#(
    parameter int WIDTH = impartitor_16b_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] r_o,
    output logic             div_zero_o
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state_q;
    logic [WIDTH-1:0]   sh_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH:0]     rem_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   q_q;
    logic [WIDTH-1:0]   r_q;
    logic               div_zero_q;

    logic [WIDTH:0]     p_w;
    logic [WIDTH:0]     diff_w;
    logic               borrow_w;
    logic [WIDTH:0]     rem_d;
    logic [WIDTH-1:0]   sh_d;

    assign p_w = {rem_q[WIDTH-1:0], sh_q[WIDTH-1]};

    impartitor_16b_scazator_cla #(
        .N (WIDTH + 1)
    ) u_sub (
        .x_i      (p_w),
        .y_i      ({1'b0, b_q}),
        .diff_o   (diff_w),
        .borrow_o (borrow_w)
    );

    // Restore on borrow; the quotient bit is the inverted borrow.
    always_comb begin
        rem_d = borrow_w ? p_w : diff_w;
        sh_d  = {sh_q[WIDTH-2:0], ~borrow_w};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sh_q       <= '0;
            b_q        <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            q_q        <= '0;
            r_q        <= '0;
            div_zero_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        if (b_i != '0) begin
                            sh_q       <= a_i;
                            b_q        <= b_i;
                            rem_q      <= '0;
                            cnt_q      <= '0;
                            div_zero_q <= 1'b0;
                            busy_q     <= 1'b1;
                            state_q    <= ST_RUN;
                        end else begin
                            q_q        <= '1;
                            r_q        <= a_i;
                            div_zero_q <= 1'b1;
                            done_q     <= 1'b1;
                            state_q    <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    rem_q <= rem_d;
                    sh_q  <= sh_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        q_q     <= sh_d;
                        r_q     <= rem_d[WIDTH-1:0];
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign q_o        = q_q;
    assign r_o        = r_q;
    assign div_zero_o = div_zero_q;

endmodule

`default_nettype wire

// File: tb/tb_impartitor_16b.sv
// ============================================================================
//  tb_impartitor_16b
//  Directed self-checking bench for impartitor_16b with a cycle-level model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_impartitor_16b;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done, div_zero;
    logic [15:0] q, r;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    impartitor_16b dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .a_i        (a),
        .b_i        (b),
        .busy_o     (busy),
        .done_o     (done),
        .q_o        (q),
        .r_o        (r),
        .div_zero_o (div_zero)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an accepted divide finishes 16 edges after the start edge, done
    // lasts one cycle; divide-by-zero reports on the start edge itself.
    int          m_left = 0;
    logic        m_busy = 0, m_done = 0, m_dz = 0;
    logic [15:0] m_q = 0, m_r = 0, m_pq = 0, m_pr = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_left = 0; m_busy = 0; m_done = 0; m_dz = 0; m_q = 0; m_r = 0;
        end else begin
            m_done = 0;
            if (m_left == 0) begin
                if (start) begin
                    if (b != 0) begin
                        m_left = 17; m_busy = 1; m_dz = 0;
                        m_pq = a / b; m_pr = a % b;
                    end else begin
                        m_left = 1; m_done = 1; m_dz = 1; m_q = 16'hFFFF; m_r = a;
                    end
                end
            end else begin
                m_left--;
                if (m_left == 1) begin
                    m_done = 1; m_busy = 0; m_q = m_pq; m_r = m_pr;
                end
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("q", 32'(q), 32'(m_q));
            chk("r", 32'(r), 32'(m_r));
            chk("div_zero", 32'(div_zero), 32'(m_dz));
            if (done === 1'b1) n_done++;
        end
    end

    task automatic pulse(input logic [15:0] av, input logic [15:0] bv);
        @(negedge clk);
        start = 1'b1; a = av; b = bv;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 40; k++) begin
            if (done === 1'b1) break;
            @(negedge clk);
        end
        if (k == 40) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_div(input logic [15:0] av, input logic [15:0] bv,
                           input logic [15:0] eq, input logic [15:0] er, input logic edz);
        pulse(av, bv);
        wait_done();
        chk("lit_q", 32'(q), 32'(eq));
        chk("lit_r", 32'(r), 32'(er));
        chk("lit_dz", 32'(div_zero), 32'(edz));
        chk("model_q", 32'(m_q), 32'(eq));
        chk("model_r", 32'(m_r), 32'(er));
    endtask

    initial begin
        int d0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_r", 32'(r), 32'd0);
        rst_n = 1'b1;

        run_div(16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
        run_div(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0);
        run_div(16'hCAE6, 16'hCAE6, 16'd1, 16'd0, 1'b0);
        run_div(16'd5, 16'd9, 16'd0, 16'd5, 1'b0);
        run_div(16'hCAE6, 16'h00DC, 16'h00EC, 16'h0016, 1'b0);
        run_div(16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1);
        run_div(16'd65000, 16'd255, 16'd254, 16'd230, 1'b0);

        // Start during RUN must be ignored.
        d0 = n_done;
        pulse(16'd100, 16'd7);
        repeat (5) @(negedge clk);
        pulse(16'd9, 16'd3);
        wait_done();
        chk("mid_q", 32'(q), 32'd14);
        chk("mid_r", 32'(r), 32'd2);
        repeat (4) @(negedge clk);
        chk("mid_done_count", 32'(n_done - d0), 32'd1);

        // Reset at iteration 8 discards the operation.
        pulse(16'd1000, 16'd10);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        d0 = n_done;
        repeat (20) @(negedge clk);
        chk("rst_mid_done_count", 32'(n_done - d0), 32'd0);
        chk("rst_mid_q", 32'(q), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        run_div(16'd1000, 16'd10, 16'd100, 16'd0, 1'b0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
